// File: rtl/branch_outcome_tracker.sv
// Branch outcome tracker: IF prediction, ID/EX prediction records,
// EX resolution with predictor training/rollback, flush and redirect.
module branch_outcome_tracker #(
   parameter int JUMP_STATUS_COUNTER_WIDTH = 2,
   parameter int STAT_WIDTH                = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 PL_stall,
   input  logic                                 is_branch_if,
   input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] HP_count,
   input  logic [31:0]                          pc_if,
   input  logic [31:0]                          target_if,
   input  logic                                 ex_resolve,
   input  logic                                 ex_taken,
   output logic                                 predict_taken_if,
   output logic                                 corrected_en,
   output logic                                 corrected_result,
   output logic                                 rollback_en_ex,
   output logic                                 rollback_en_id,
   output logic                                 prediction_result_branch_failed,
   output logic                                 flush,
   output logic                                 redirect_valid,
   output logic [31:0]                          redirect_pc,
   output logic [STAT_WIDTH-1:0]                branch_cnt,
   output logic [STAT_WIDTH-1:0]                mispredict_cnt
);

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic        r_id_valid;
   logic        r_id_pred;
   logic [31:0] r_id_pc;
   logic [31:0] r_id_tgt;

   logic        r_ex_valid;
   logic        r_ex_pred;
   logic [31:0] r_ex_pc;
   logic [31:0] r_ex_tgt;

   logic [STAT_WIDTH-1:0] r_branch_cnt;
   logic [STAT_WIDTH-1:0] r_mispredict_cnt;

   logic        w_accept;
   logic        w_correct;
   logic        w_mispredict;
   logic [31:0] w_fallthru;
   logic        w_unused_count;

   // Only the sign bit of the saturating counter drives the decision.
   assign w_unused_count   = ^HP_count;
   assign predict_taken_if = is_branch_if & HP_count[JUMP_STATUS_COUNTER_WIDTH-1];

   assign w_accept     = ex_resolve & r_ex_valid & (r_state == RUN);
   assign w_correct    = w_accept & (ex_taken == r_ex_pred);
   assign w_mispredict = w_accept & (ex_taken != r_ex_pred);
   assign w_fallthru   = r_ex_pc + 32'd4;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt                     = r_state;
      corrected_en                    = 1'b0;
      corrected_result                = 1'b0;
      rollback_en_ex                  = 1'b0;
      rollback_en_id                  = 1'b0;
      prediction_result_branch_failed = 1'b0;
      flush                           = 1'b0;
      redirect_valid                  = 1'b0;
      redirect_pc                     = 32'd0;
      unique case (r_state)
         RUN: begin
            if (w_correct) begin
               corrected_en     = 1'b1;
               corrected_result = ex_taken;
            end
            if (w_mispredict) begin
               rollback_en_ex                  = 1'b1;
               rollback_en_id                  = r_id_valid;
               prediction_result_branch_failed = r_ex_pred;
               flush                           = 1'b1;
               redirect_valid                  = 1'b1;
               redirect_pc = ex_taken ? r_ex_tgt : w_fallthru;
               w_state_nxt                     = RECOVER;
            end
         end
         RECOVER: begin
            w_state_nxt = RUN;
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase
   end

   // A flush kills both in-flight records even when the pipe is stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_id_valid <= 1'b0;
         r_id_pred  <= 1'b0;
         r_id_pc    <= 32'd0;
         r_id_tgt   <= 32'd0;
         r_ex_valid <= 1'b0;
         r_ex_pred  <= 1'b0;
         r_ex_pc    <= 32'd0;
         r_ex_tgt   <= 32'd0;
      end else begin
         if (!PL_stall) begin
            r_id_valid <= is_branch_if;
            r_id_pred  <= predict_taken_if;
            r_id_pc    <= pc_if;
            r_id_tgt   <= target_if;
            r_ex_valid <= r_id_valid;
            r_ex_pred  <= r_id_pred;
            r_ex_pc    <= r_id_pc;
            r_ex_tgt   <= r_id_tgt;
         end
         if (w_mispredict) begin
            r_id_valid <= 1'b0;
            r_ex_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_branch_cnt     <= '0;
         r_mispredict_cnt <= '0;
      end else begin
         if (w_accept && !(&r_branch_cnt)) begin
            r_branch_cnt <= r_branch_cnt + 1'b1;
         end
         if (w_mispredict && !(&r_mispredict_cnt)) begin
            r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
         end
      end
   end

   assign branch_cnt     = r_branch_cnt;
   assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_outcome_tracker.sv
// Directed self-checking bench for branch_outcome_tracker.
module tb_branch_outcome_tracker;

   logic        clk;
   logic        rst_n;
   logic        PL_stall;
   logic        is_branch_if;
   logic [1:0]  HP_count;
   logic [31:0] pc_if;
   logic [31:0] target_if;
   logic        ex_resolve;
   logic        ex_taken;
   logic        predict_taken_if;
   logic        corrected_en;
   logic        corrected_result;
   logic        rollback_en_ex;
   logic        rollback_en_id;
   logic        prediction_result_branch_failed;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [15:0] branch_cnt;
   logic [15:0] mispredict_cnt;

   int errors = 0;
   int checks = 0;

   branch_outcome_tracker dut (
      .clk                             (clk),
      .rst_n                           (rst_n),
      .PL_stall                        (PL_stall),
      .is_branch_if                    (is_branch_if),
      .HP_count                        (HP_count),
      .pc_if                           (pc_if),
      .target_if                       (target_if),
      .ex_resolve                      (ex_resolve),
      .ex_taken                        (ex_taken),
      .predict_taken_if                (predict_taken_if),
      .corrected_en                    (corrected_en),
      .corrected_result                (corrected_result),
      .rollback_en_ex                  (rollback_en_ex),
      .rollback_en_id                  (rollback_en_id),
      .prediction_result_branch_failed (prediction_result_branch_failed),
      .flush                           (flush),
      .redirect_valid                  (redirect_valid),
      .redirect_pc                     (redirect_pc),
      .branch_cnt                      (branch_cnt),
      .mispredict_cnt                  (mispredict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Resolution bundle: {ce,cr,rex,rid,pf,flush,rv} then redirect_pc.
   task automatic chk_res(input string tag, input logic [6:0] f, input logic [31:0] pc);
      chk(tag, {25'd0, corrected_en, corrected_result, rollback_en_ex,
                rollback_en_id, prediction_result_branch_failed, flush,
                redirect_valid, redirect_pc},
          {25'd0, f, pc});
   endtask

   task automatic chk_cnt(input string tag, input logic [15:0] b, input logic [15:0] m);
      chk(tag, {32'd0, branch_cnt, mispredict_cnt}, {32'd0, b, m});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_if(input logic br, input logic [1:0] hp,
                           input logic [31:0] pc, input logic [31:0] tg);
      is_branch_if = br;
      HP_count     = hp;
      pc_if        = pc;
      target_if    = tg;
   endtask

   initial begin
      rst_n = 1'b0; PL_stall = 1'b0; ex_resolve = 1'b0; ex_taken = 1'b0;
      drive_if(1'b0, 2'b00, 32'd0, 32'd0);
      step(); step();
      rst_n = 1'b1;
      #1;
      chk_res("reset_outputs", 7'b0000000, 32'd0);
      chk_cnt("reset_counts", 16'd0, 16'd0);
      chk("reset_pred_if", {63'd0, predict_taken_if}, 64'd0);

      // Correct taken prediction
      step();
      drive_if(1'b1, 2'b10, 32'h100, 32'h180);
      #1;
      chk("pred_if_taken", {63'd0, predict_taken_if}, 64'd1);
      step();
      drive_if(1'b0, 2'b00, 32'd0, 32'd0);
      step();
      ex_resolve = 1'b1; ex_taken = 1'b1;
      #1;
      chk_res("correct_taken", 7'b1100000, 32'd0);
      step();
      ex_resolve = 1'b0;
      #1;
      chk_cnt("cnt_after_correct", 16'd1, 16'd0);

      // Mispredict: predicted not-taken, resolved taken
      drive_if(1'b1, 2'b01, 32'h100, 32'h180);
      #1;
      chk("pred_if_nt", {63'd0, predict_taken_if}, 64'd0);
      step();
      drive_if(1'b0, 2'b00, 32'd0, 32'd0);
      step();
      ex_resolve = 1'b1; ex_taken = 1'b1;
      #1;
      chk_res("mispredict_taken", 7'b0010011, 32'h180);
      step();
      #1;
      chk_res("recover_ignored", 7'b0000000, 32'd0);
      chk_cnt("cnt_after_misp", 16'd2, 16'd1);
      step();
      ex_resolve = 1'b0;
      #1;
      chk_cnt("cnt_recover_no_count", 16'd2, 16'd1);

      // Back-to-back branches, older one mispredicts
      drive_if(1'b1, 2'b00, 32'h200, 32'h280);
      step();
      drive_if(1'b1, 2'b11, 32'h204, 32'h2C0);
      step();
      drive_if(1'b0, 2'b00, 32'd0, 32'd0);
      ex_resolve = 1'b1; ex_taken = 1'b1;
      #1;
      chk_res("misp_with_id", 7'b0011011, 32'h280);
      step();
      #1;
      chk_res("b2b_recover", 7'b0000000, 32'd0);
      step();
      #1;
      chk_res("b2b_squashed_id", 7'b0000000, 32'd0);
      step();
      ex_resolve = 1'b0;
      #1;
      chk_cnt("cnt_after_b2b", 16'd3, 16'd2);

      // Wraparound redirect under stall
      drive_if(1'b1, 2'b11, 32'hFFFF_FFFC, 32'h40);
      step();
      drive_if(1'b0, 2'b00, 32'd0, 32'd0);
      step();
      PL_stall = 1'b1; ex_resolve = 1'b1; ex_taken = 1'b0;
      #1;
      chk_res("misp_wrap_stall", 7'b0010111, 32'h0);
      step();
      #1;
      chk_res("stall_no_repulse", 7'b0000000, 32'd0);
      step();
      PL_stall = 1'b0;
      #1;
      chk_res("stall_flushed_rec", 7'b0000000, 32'd0);
      step();
      ex_resolve = 1'b0;
      #1;
      chk_cnt("cnt_after_wrap", 16'd4, 16'd3);

      // Stall holds the EX record: same branch resolves again
      drive_if(1'b1, 2'b10, 32'h300, 32'h380);
      step();
      drive_if(1'b0, 2'b00, 32'd0, 32'd0);
      step();
      PL_stall = 1'b1; ex_resolve = 1'b1; ex_taken = 1'b1;
      #1;
      chk_res("stall_correct", 7'b1100000, 32'd0);
      step();
      ex_taken = 1'b0;
      #1;
      chk_res("stall_held_rec", 7'b0010111, 32'h304);
      step();
      PL_stall = 1'b0; ex_resolve = 1'b0;
      #1;
      chk_cnt("cnt_after_hold", 16'd6, 16'd4);

      // Saturate branch_cnt with correct not-taken resolutions
      drive_if(1'b1, 2'b00, 32'h400, 32'h480);
      ex_resolve = 1'b1; ex_taken = 1'b0;
      for (int i = 0; i < 65545; i++) step();
      chk_cnt("cnt_saturate", 16'hFFFF, 16'd4);

      ex_taken = 1'b1;
      #1;
      chk_res("sat_mispredict", 7'b0011011, 32'h480);
      step();
      chk_cnt("cnt_sat_misp", 16'hFFFF, 16'd5);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk_res("post_reset_quiet", 7'b0000000, 32'd0);
      chk_cnt("post_reset_cnt", 16'd0, 16'd0);
      step();
      step();
      ex_taken = 1'b0;
      #1;
      chk_res("post_reset_run", 7'b1000000, 32'd0);
      step();
      ex_resolve = 1'b0; is_branch_if = 1'b0;
      #1;
      chk_cnt("post_reset_count", 16'd1, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
